// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: sequencer <-> pipeline control signals
interface pipe_ctrl_if #(parameter int PC_W = 64, parameter int LAT_W = 4);
  logic             ex_fire_i;
  logic             ex_multi_i;
  logic [LAT_W-1:0] ex_lat_i;
  logic             ID_valid_i;
  logic             EX_valid_i;
  logic             redirect_i;
  logic [PC_W-1:0]  redirect_pc_i;
  logic             halt_req_i;
  logic             resume_req_i;
  logic             step_req_i;
  logic             ex_run_o;
  logic             fetch_en_o;
  logic             flush_o;
  logic             redir_valid_o;
  logic [PC_W-1:0]  redir_pc_o;
  logic             halted_o;
  logic [2:0]       state_o;
  modport master (
    input  ex_fire_i, ex_multi_i, ex_lat_i, ID_valid_i, EX_valid_i, redirect_i,
           redirect_pc_i, halt_req_i, resume_req_i, step_req_i,
    output ex_run_o, fetch_en_o, flush_o, redir_valid_o, redir_pc_o, halted_o, state_o
  );
  modport slave (
    output ex_fire_i, ex_multi_i, ex_lat_i, ID_valid_i, EX_valid_i, redirect_i,
           redirect_pc_i, halt_req_i, resume_req_i, step_req_i,
    input  ex_run_o, fetch_en_o, flush_o, redir_valid_o, redir_pc_o, halted_o, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for EX stalls, flush/redirect and debug halt/step
module pipe_ctrl #(
  parameter int PC_W       = 64,
  parameter int LAT_W      = 4,
  parameter bit RESET_HALT = 1'b0
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.master p
);
  typedef enum logic [2:0] {
    RUN = 3'd0, EXWAIT = 3'd1, FLUSH = 3'd2, DRAIN = 3'd3, HALTED = 3'd4, STEP = 3'd5
  } state_t;
  state_t state, nxt;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic [PC_W-1:0] redir_pc;
  logic halt_pend, redir_pend, ret_drain;
  logic redir, halt;
  assign redir = p.redirect_i || redir_pend;
  assign halt  = p.halt_req_i || halt_pend;
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    case (state)
      RUN: begin
        if (redir) nxt = FLUSH;
        else if (halt) nxt = DRAIN;
        else if (p.ex_fire_i && p.ex_multi_i && p.ex_lat_i != '0) begin
          nxt   = EXWAIT;
          cnt_n = p.ex_lat_i;
        end
      end
      EXWAIT: begin
        cnt_n = cnt - LAT_W'(1);
        nxt   = (cnt == LAT_W'(1)) ? RUN : EXWAIT;
      end
      FLUSH:   nxt = (halt_pend || ret_drain) ? DRAIN : RUN;
      DRAIN:   nxt = redir ? FLUSH : (!p.ID_valid_i && !p.EX_valid_i) ? HALTED : DRAIN;
      HALTED:  nxt = p.resume_req_i ? RUN : p.step_req_i ? STEP : HALTED;
      STEP:    nxt = redir ? FLUSH : DRAIN;
      default: nxt = RUN;
    endcase
  end
  // ret_drain remembers whether the flush was entered from a debug drain or step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RESET_HALT ? HALTED : RUN;
      cnt        <= '0;
      redir_pc   <= '0;
      halt_pend  <= 1'b0;
      redir_pend <= 1'b0;
      ret_drain  <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_n;
      ret_drain  <= (state == DRAIN) || (state == STEP);
      if (p.redirect_i && state != FLUSH) redir_pc <= p.redirect_pc_i;
      redir_pend <= (nxt == FLUSH) ? 1'b0 : (p.redirect_i && state != FLUSH) ? 1'b1 : redir_pend;
      halt_pend  <= (nxt == HALTED) ? 1'b0 :
                    (p.halt_req_i && state inside {RUN, EXWAIT, FLUSH, STEP}) ? 1'b1 : halt_pend;
    end
  end
  assign p.ex_run_o      = state != EXWAIT;
  assign p.fetch_en_o    = state inside {RUN, EXWAIT, STEP};
  assign p.flush_o       = state == FLUSH;
  assign p.redir_valid_o = state == FLUSH;
  assign p.halted_o      = state == HALTED;
  assign p.redir_pc_o    = redir_pc;
  assign p.state_o       = state;
endmodule
